// File: rtl/addsub_serial_ctrl.sv
// rtl/addsub_serial_ctrl.sv - WIDTH-bit add/sub through one shared 4-bit slice, LSB nibble first
// Optional abort input enabled by defining ADDSUB_SERIAL_ABORT_EN.
module addsub_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ADDSUB_SERIAL_ABORT_EN
    input  logic             abort,
`endif
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_r, b_r, partial, partial_next;
    logic             ctrl_r, cy;
    logic [CW-1:0]    cnt;
    logic [3:0]       a_nib, b_nib, res;
    logic [4:0]       full;
    logic             cout, c_msb_in, last, abort_run;

`ifdef ADDSUB_SERIAL_ABORT_EN
    assign abort_run = abort;
`else
    assign abort_run = 1'b0;
`endif

    // Shared slice: subtract is a + ~b + 1, the +1 coming from the carry flop preload.
    always_comb begin
        a_nib        = a_r[{cnt, 2'b00} +: 4];
        b_nib        = b_r[{cnt, 2'b00} +: 4] ^ {4{ctrl_r}};
        full         = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, cy};
        res          = full[3:0];
        cout         = full[4];
        c_msb_in     = a_nib[3] ^ b_nib[3] ^ res[3];
        partial_next = partial;
        partial_next[{cnt, 2'b00} +: 4] = res;
        last         = (cnt == CW'(NIBBLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (abort_run) state_next = IDLE;
                     else if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        done  = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            ctrl_r   <= 1'b0;
            cy       <= 1'b0;
            cnt      <= '0;
            partial  <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_r    <= a;
                    b_r    <= b;
                    ctrl_r <= ctrl;
                    cy     <= ctrl;
                    cnt    <= '0;
                end
                RUN: if (!abort_run) begin
                    partial <= partial_next;
                    cy      <= cout;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        sum      <= partial_next;
                        carry    <= cout;
                        overflow <= c_msb_in ^ cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
